// File: rtl/div_unit_pkg.sv
// Shared types and constants for the RV32M multi-cycle divider.
package div_unit_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CNT_W      = $clog2(DIV_DATA_WIDTH);

  // Encoding matches funct3[1:0] of the M-extension divide instructions.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] diff;

  // The extra top bit acts as the borrow flag of the trial subtraction.
  assign shifted = {rem_i, quo_i[DATA_WIDTH-1]};
  assign diff    = shifted - {2'b00, divisor_i};

  always_comb begin
    rem_o = shifted[DATA_WIDTH:0];
    quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
    if (!diff[DATA_WIDTH+1]) begin
      rem_o = diff[DATA_WIDTH:0];
      quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Fixed-latency RV32M divider (DIV/DIVU/REM/REMU) for the Execute stage,
// with stall request, abort, and sign/special-case handling around div_step.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  DivStartE,
  input  logic [1:0]            DivOpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  DivKillE,
  output logic                  DivBusyE,
  output logic                  DivDoneE,
  output logic [DATA_WIDTH-1:0] DivResultE
);

  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t            state_q, state_d;
  logic [DIV_CNT_W-1:0]  count_q, count_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  div_op_t               op_q, op_d;
  logic                  negQ_q, negQ_d;
  logic                  negR_q, negR_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  div_op_t               opIn;
  logic                  inSigned;
  logic                  divZero;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] absA, absB;
  logic [DATA_WIDTH-1:0] specialResult;
  logic [DATA_WIDTH:0]   stepRem;
  logic [DATA_WIDTH-1:0] stepQuo;
  logic [DATA_WIDTH-1:0] quoFix, remFix, finalResult;
  logic                  remOp;

  assign opIn     = div_op_t'(DivOpE);
  assign inSigned = (opIn == OP_DIV) || (opIn == OP_REM);
  assign divZero  = (SrcBE == '0);
  assign overflow = inSigned && (SrcAE == MinNeg) && (SrcBE == '1);
  assign absA     = (inSigned && SrcAE[DATA_WIDTH-1]) ? -SrcAE : SrcAE;
  assign absB     = (inSigned && SrcBE[DATA_WIDTH-1]) ? -SrcBE : SrcBE;

  // Divide-by-zero: quotient all ones, remainder = dividend.
  // Overflow: quotient = dividend (the most negative value), remainder 0.
  always_comb begin
    specialResult = divZero ? '1 : MinNeg;
    if ((opIn == OP_REM) || (opIn == OP_REMU)) begin
      specialResult = divZero ? SrcAE : '0;
    end
  end

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (stepRem),
    .quo_o     (stepQuo)
  );

  // The result is taken straight from the last step so it is registered on entry to DONE.
  assign remOp       = (op_q == OP_REM) || (op_q == OP_REMU);
  assign quoFix      = negQ_q ? -stepQuo : stepQuo;
  assign remFix      = negR_q ? -stepRem[DATA_WIDTH-1:0] : stepRem[DATA_WIDTH-1:0];
  assign finalResult = remOp ? remFix : quoFix;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    op_d      = op_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (DivStartE && !DivKillE) begin
          op_d   = opIn;
          negQ_d = inSigned && (SrcAE[DATA_WIDTH-1] ^ SrcBE[DATA_WIDTH-1]);
          negR_d = inSigned && SrcAE[DATA_WIDTH-1];
          if (divZero || overflow) begin
            result_d = specialResult;
            state_d  = S_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = absA;
            divisor_d = absB;
            count_d   = DIV_CNT_W'(DATA_WIDTH - 1);
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (DivKillE) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = stepRem;
          quo_d   = stepQuo;
          count_d = count_q - 1'b1;
          if (count_q == '0) begin
            result_d = finalResult;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      op_q      <= OP_DIV;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      op_q      <= op_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      result_q  <= result_d;
    end
  end

  // Busy is combinational so the instruction is held in Execute from its first cycle.
  assign DivBusyE   = ((state_q == S_IDLE) && DivStartE && !DivKillE) ||
                      ((state_q == S_RUN) && !DivKillE);
  assign DivDoneE   = (state_q == S_DONE) && !DivKillE;
  assign DivResultE = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, kill/reset/back-to-back
// timing and randomized operations against an arithmetic reference model.
module tb_div_unit;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        DivStartE;
  logic [1:0]  DivOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        DivKillE;
  logic        DivBusyE;
  logic        DivDoneE;
  logic [31:0] DivResultE;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastResult = 32'h0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .DivStartE  (DivStartE),
    .DivOpE     (DivOpE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .DivKillE   (DivKillE),
    .DivBusyE   (DivBusyE),
    .DivDoneE   (DivDoneE),
    .DivResultE (DivResultE)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // RISC-V M-extension semantics written with plain arithmetic.
  function automatic logic [31:0] refDiv(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int latencyOf(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation starting at cycle 0 and observes cycles 0..lat+tail.
  // killAt >= 0 pulses DivKillE in that cycle; startInDone re-asserts DivStartE in DONE.
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int killAt, input int tail,
                       input bit startInDone, input string name);
    int          lat;
    int          expBusy;
    int          expDone;
    int          busyCnt;
    int          doneCnt;
    int          doneAt;
    logic [31:0] res;
    lat     = latencyOf(op, a, b);
    expBusy = (killAt >= 0 && killAt < lat) ? killAt : lat;
    expDone = (killAt >= 0 && killAt <= lat) ? 0 : 1;
    busyCnt = 0;
    doneCnt = 0;
    doneAt  = -1;
    res     = 'x;
    for (int c = 0; c <= lat + tail; c++) begin
      @(negedge clk);
      DivStartE = (c == 0) || (startInDone && c == lat);
      DivKillE  = (c == killAt);
      DivOpE    = op;
      SrcAE     = a;
      SrcBE     = b;
      #1;
      if (DivBusyE === 1'b1) busyCnt++;
      if (DivDoneE === 1'b1) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt = c;
          res    = DivResultE;
        end
      end
    end
    checks++;
    if (busyCnt !== expBusy) begin
      errors++;
      $display("[TB] FAIL %s busy_cycles: got %0d, expected %0d", name, busyCnt, expBusy);
    end
    checks++;
    if (doneCnt !== expDone) begin
      errors++;
      $display("[TB] FAIL %s done_cycles: got %0d, expected %0d", name, doneCnt, expDone);
    end
    if (expDone == 1) begin
      checks++;
      if (doneAt !== lat) begin
        errors++;
        $display("[TB] FAIL %s done_cycle: got %0d, expected %0d", name, doneAt, lat);
      end
      checks++;
      if (res !== exp) begin
        errors++;
        $display("[TB] FAIL %s result: got %h, expected %h", name, res, exp);
      end
      lastResult = exp;
    end else if (killAt < lat) begin
      checks++;
      if (DivResultE !== lastResult) begin
        errors++;
        $display("[TB] FAIL %s result_held: got %h, expected %h", name, DivResultE, lastResult);
      end
    end else begin
      lastResult = exp;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    DivStartE = 1'b0;
    DivKillE  = 1'b0;
    DivOpE    = DIV;
    SrcAE     = 32'h0;
    SrcBE     = 32'h0;
    #12;
    checks++;
    if (DivBusyE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", DivBusyE);
    end
    checks++;
    if (DivDoneE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b, expected 0", DivDoneE);
    end
    checks++;
    if (DivResultE !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_result: got %h, expected 00000000", DivResultE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lastResult = 32'h0;
  endtask

  task automatic test_unsigned();
    runOp(DIVU, 32'd100, 32'd7, 32'd14, -1, 1, 1'b0, "divu_100_7");
    runOp(REMU, 32'd100, 32'd7, 32'd2, -1, 1, 1'b0, "remu_100_7");
    runOp(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, -1, 1, 1'b0, "divu_max_1");
  endtask

  task automatic test_signed();
    runOp(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1, 1, 1'b0, "div_m7_2");
    runOp(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1, 1, 1'b0, "rem_m7_2");
    runOp(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, -1, 1, 1'b0, "div_7_m2");
    runOp(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, -1, 1, 1'b0, "rem_7_m2");
  endtask

  task automatic test_div_zero();
    runOp(DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, -1, 1, 1'b0, "div_5_0");
    runOp(REMU, 32'd5, 32'd0, 32'd5, -1, 1, 1'b0, "remu_5_0");
    runOp(REM, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, -1, 1, 1'b0, "rem_neg_0");
  endtask

  task automatic test_overflow();
    runOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, 1, 1'b0, "div_ovf");
    runOp(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, -1, 1, 1'b0, "rem_ovf");
    runOp(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, -1, 1, 1'b0, "divu_no_ovf");
  endtask

  task automatic test_kill();
    runOp(DIVU, 32'hDEAD_BEEF, 32'h123, 32'h0, 10, 3, 1'b0, "kill_run10");
    runOp(DIVU, 32'd9, 32'd3, 32'd3, -1, 1, 1'b0, "divu_9_3_after_kill");
    runOp(DIV, 32'd50, 32'd5, 32'h0, 0, 3, 1'b0, "kill_with_start");
    runOp(DIVU, 32'd100, 32'd7, 32'd14, 33, 2, 1'b0, "kill_in_done");
    runOp(DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 2, 1'b0, "kill_in_done_special");
  endtask

  task automatic test_back_to_back();
    runOp(DIVU, 32'd1000, 32'd10, 32'd100, -1, 0, 1'b0, "b2b_first");
    runOp(REM, 32'hFFFF_FF00, 32'd7, refDiv(REM, 32'hFFFF_FF00, 32'd7), -1, 0, 1'b0, "b2b_second");
    runOp(DIV, 32'd3, 32'd0, 32'hFFFF_FFFF, -1, 0, 1'b0, "b2b_special");
    runOp(DIVU, 32'd77, 32'd11, 32'd7, -1, 2, 1'b1, "start_in_done_ignored");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pickOperand();
      b  = pickOperand();
      runOp(op, a, b, refDiv(op, a, b), -1, int'($urandom_range(0, 2)), 1'b0,
            $sformatf("rand%0d_op%0d_%h_%h", i, op, a, b));
    end
  endtask

  task automatic test_reset_mid();
    runOp(DIVU, 32'd100, 32'd7, 32'd14, -1, 0, 1'b0, "pre_reset_op");
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      DivStartE = (c == 0);
      DivKillE  = 1'b0;
      DivOpE    = DIVU;
      SrcAE     = 32'd1000;
      SrcBE     = 32'd3;
    end
    #1;
    checks++;
    if (DivBusyE !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_busy_before_reset: got %b, expected 1", DivBusyE);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (DivBusyE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_busy: got %b, expected 0", DivBusyE);
    end
    checks++;
    if (DivDoneE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_done: got %b, expected 0", DivDoneE);
    end
    checks++;
    if (DivResultE !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_result: got %h, expected 00000000", DivResultE);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    lastResult = 32'h0;
    runOp(DIVU, 32'd1000, 32'd3, 32'd333, -1, 1, 1'b0, "after_reset_op");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_kill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
